// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
`timescale 1ns/1ps
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  localparam int unsigned MIN_PRESCALE  = 8;
  localparam int unsigned SAMPLE_OFFSET = 2;

endpackage

// File: rtl/uart_rx_fsm.sv
// UART receive control FSM: sequences counter, sampler, deserializer and the
// start/parity/stop checkers over one frame, then qualifies the frame.
`timescale 1ns/1ps
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PRESCALE_BITS = 6,
  parameter int unsigned TX_BITS       = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     RX_IN,
  input  logic                     PAR_EN,
  input  logic [PRESCALE_BITS-1:0] prescale,
  input  logic [TX_BITS-1:0]       bit_cnt,
  input  logic [PRESCALE_BITS-1:0] edge_cnt,
  input  logic                     strt_glitch,
  input  logic                     par_err,
  input  logic                     stp_err,
  output logic                     cnt_en,
  output logic                     dat_samp_en,
  output logic                     deser_en,
  output logic                     strt_chk_en,
  output logic                     par_chk_en,
  output logic                     stp_chk_en,
  output logic                     data_valid,
  output logic                     parity_error,
  output logic                     framing_error,
  output logic                     busy
);

  localparam int unsigned CW = PRESCALE_BITS + 1;

  state_t        state;
  logic          par_flag;
  logic [CW-1:0] p_ext;
  logic [CW-1:0] edge_ext;
  logic [CW-1:0] samp_pt;
  logic [CW-1:0] bit_end;
  logic          at_samp;
  logic          at_end;
  logic          p_ok;
  logic          start_seen;
  logic          in_frame;

  // One extra bit keeps P/2+2 and P-1 free of wrap for any prescale value.
  assign p_ext      = {1'b0, prescale};
  assign edge_ext   = {1'b0, edge_cnt};
  assign samp_pt    = (p_ext >> 1) + CW'(SAMPLE_OFFSET);
  assign bit_end    = p_ext - CW'(1);
  assign at_samp    = (edge_ext == samp_pt);
  assign at_end     = (edge_ext == bit_end);
  assign p_ok       = (p_ext >= CW'(MIN_PRESCALE));
  assign start_seen = (state == IDLE) && !RX_IN && p_ok;

  always_comb begin
    in_frame    = 1'b0;
    cnt_en      = 1'b0;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    busy        = 1'b0;
    in_frame    = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);
    cnt_en      = in_frame || start_seen;
    dat_samp_en = cnt_en;
    strt_chk_en = (state == START)  && at_samp;
    deser_en    = (state == DATA)   && at_samp;
    par_chk_en  = (state == PARITY) && at_samp;
    stp_chk_en  = (state == STOP)   && at_samp;
    busy        = (state != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      par_flag      <= 1'b0;
      data_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE:   if (start_seen) state <= START;
        START:  if (at_end) state <= strt_glitch ? IDLE : DATA;
        DATA:   if (at_end && (bit_cnt == TX_BITS'(DATA_WIDTH)))
                  state <= PAR_EN ? PARITY : STOP;
        PARITY: if (at_end) begin
                  par_flag <= par_err;
                  state    <= STOP;
                end
        STOP:   if (at_end) state <= DONE;
        DONE: begin
          parity_error  <= par_flag;
          framing_error <= stp_err;
          data_valid    <= !par_flag && !stp_err;
          par_flag      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter and deserializer.
`timescale 1ns/1ps
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       par_en;
  logic [5:0] prescale;
  logic [3:0] bit_cnt;
  logic [5:0] edge_cnt;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic       cnt_en, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       data_valid, parity_error, framing_error, busy;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int         cyc = 0, det_cyc = 0, dv_last = 0, dv_lat = 0, dv_gap = 0;
  int         n_deser = 0, n_strt = 0, n_par = 0, n_stp = 0, n_dv = 0, deser_bad = 0;
  int         s_exp = 6;
  logic [7:0] shreg = '0;
  logic [7:0] dv_q[$];
  logic [7:0] b;
  int         v0, d0, s0, p0, t0, qsz;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_BITS(6), .TX_BITS(4)) dut (
    .CLK(clk), .RST(rst), .RX_IN(rx_in), .PAR_EN(par_en), .prescale(prescale),
    .bit_cnt(bit_cnt), .edge_cnt(edge_cnt), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err), .cnt_en(cnt_en), .dat_samp_en(dat_samp_en),
    .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .parity_error(parity_error),
    .framing_error(framing_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared edge/bit counter as it sits beside the FSM in the receiver.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!cnt_en) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (edge_cnt == prescale - 6'd1) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + 6'd1;
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (deser_en) begin
      shreg   = {rx_in, shreg[7:1]};
      n_deser = n_deser + 1;
      if (32'(edge_cnt) != s_exp) deser_bad = deser_bad + 1;
    end
    if (strt_chk_en) n_strt = n_strt + 1;
    if (par_chk_en)  n_par  = n_par + 1;
    if (stp_chk_en)  n_stp  = n_stp + 1;
    if (data_valid) begin
      n_dv    = n_dv + 1;
      dv_lat  = cyc - det_cyc;
      dv_gap  = cyc - dv_last;
      dv_last = cyc;
      dv_q.push_back(shreg);
    end
    if (!busy && cnt_en) det_cyc = cyc;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int unsigned p);
    rx_in = v;
    step(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic stop_v,
                            input int unsigned p);
    par_en = pe;
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(^d, p);
    drive_bit(stop_v, p);
    rx_in = 1'b1;
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
    strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    #12;
    check_eq("rst_busy",   32'(busy), 0);
    check_eq("rst_cnt_en", 32'(cnt_en), 0);
    check_eq("rst_dv",     32'(data_valid), 0);
    check_eq("rst_pe",     32'(parity_error), 0);
    check_eq("rst_fe",     32'(framing_error), 0);
    check_eq("rst_strobes", 32'({deser_en, strt_chk_en, par_chk_en, stp_chk_en}), 0);
    @(negedge clk) rst = 1'b0;
    step(2);

    // P=8, no parity, 0xA5
    s_exp = 6; v0 = n_dv; d0 = n_deser;
    send_frame(8'hA5, 1'b0, 1'b1, 8);
    check_eq("t1_done_busy", 32'(busy), 1);
    check_eq("t1_done_cnt_en", 32'(cnt_en), 0);
    step(1);
    check_eq("t1_dv", 32'(data_valid), 1);
    check_eq("t1_pe", 32'(parity_error), 0);
    check_eq("t1_fe", 32'(framing_error), 0);
    check_eq("t1_busy_after", 32'(busy), 0);
    step(1);
    check_eq("t1_dv_pulse", 32'(data_valid), 0);
    check_eq("t1_dv_count", 32'(n_dv - v0), 1);
    check_eq("t1_latency", 32'(dv_lat), 81);
    check_eq("t1_data", 32'(dv_q[$]), 32'hA5);
    check_eq("t1_deser_count", 32'(n_deser - d0), 8);
    check_eq("t1_deser_edge", 32'(deser_bad), 0);

    // P=16, parity with forced error, then a clean frame clears status
    prescale = 6'd16; s_exp = 10; par_err = 1'b1; v0 = n_dv; p0 = n_par;
    send_frame(8'h3C, 1'b1, 1'b1, 16);
    check_eq("t2_done_busy", 32'(busy), 1);
    step(1);
    check_eq("t2_pe", 32'(parity_error), 1);
    check_eq("t2_dv", 32'(data_valid), 0);
    check_eq("t2_fe", 32'(framing_error), 0);
    step(10);
    check_eq("t2_pe_held", 32'(parity_error), 1);
    check_eq("t2_par_chk_count", 32'(n_par - p0), 1);
    par_err = 1'b0;
    send_frame(8'h81, 1'b1, 1'b1, 16);
    step(1);
    check_eq("t2_clean_dv", 32'(data_valid), 1);
    check_eq("t2_clean_pe", 32'(parity_error), 0);
    step(1);
    check_eq("t2_dv_count", 32'(n_dv - v0), 1);
    check_eq("t2_latency", 32'(dv_lat), 177);
    check_eq("t2_data", 32'(dv_q[$]), 32'h81);

    // P=32, stop bit low
    prescale = 6'd32; s_exp = 18; stp_err = 1'b1; v0 = n_dv;
    send_frame(8'hC3, 1'b0, 1'b0, 32);
    check_eq("t4_done_busy", 32'(busy), 1);
    step(1);
    check_eq("t4_fe", 32'(framing_error), 1);
    check_eq("t4_dv", 32'(data_valid), 0);
    check_eq("t4_busy_drop", 32'(busy), 0);
    check_eq("t4_pe", 32'(parity_error), 0);
    stp_err = 1'b0;
    step(2);
    check_eq("t4_dv_count", 32'(n_dv - v0), 0);
    check_eq("t4_deser_edge", 32'(deser_bad), 0);

    // P=8 start glitch: silent drop at the end of the start bit
    prescale = 6'd8; s_exp = 6; strt_glitch = 1'b1;
    v0 = n_dv; d0 = n_deser; s0 = n_strt; p0 = n_par; t0 = n_stp;
    rx_in = 1'b0;
    step(2);
    rx_in = 1'b1;
    step(5);
    check_eq("t3_busy_e7", 32'(busy), 1);
    check_eq("t3_edge7", 32'(edge_cnt), 7);
    step(1);
    check_eq("t3_idle", 32'(busy), 0);
    check_eq("t3_cnt_en", 32'(cnt_en), 0);
    step(20);
    check_eq("t3_strt_count", 32'(n_strt - s0), 1);
    check_eq("t3_no_strobes", 32'((n_deser - d0) + (n_par - p0) + (n_stp - t0)), 0);
    check_eq("t3_no_dv", 32'(n_dv - v0), 0);
    check_eq("t3_fe_kept", 32'(framing_error), 1);
    strt_glitch = 1'b0;

    // P below minimum: start ignored
    prescale = 6'd4;
    rx_in = 1'b0;
    #1;
    check_eq("tp_cnt_en_low", 32'(cnt_en), 0);
    step(3);
    check_eq("tp_busy", 32'(busy), 0);
    rx_in = 1'b1;
    prescale = 6'd8;
    step(2);

    // Reset in the middle of data bit 4 (line high there)
    b = 8'h5A; v0 = n_dv;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) drive_bit(b[i], 8);
    rx_in = b[3];
    step(3);
    check_eq("t5_bit_cnt", 32'(bit_cnt), 4);
    check_eq("t5_busy_pre", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_busy", 32'(busy), 0);
    check_eq("t5_cnt_en", 32'(cnt_en), 0);
    check_eq("t5_samp_en", 32'(dat_samp_en), 0);
    check_eq("t5_dv", 32'(data_valid), 0);
    check_eq("t5_fe", 32'(framing_error), 0);
    check_eq("t5_pe", 32'(parity_error), 0);
    @(negedge clk) rst = 1'b0;
    step(20);
    check_eq("t5_no_dv", 32'(n_dv - v0), 0);
    check_eq("t5_idle", 32'(busy), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 8);
    step(1);
    check_eq("t5_dv", 32'(data_valid), 1);
    step(1);
    check_eq("t5_data", 32'(dv_q[$]), 32'h5A);
    check_eq("t5_latency", 32'(dv_lat), 81);

    // Back-to-back frames, P=16 with parity
    prescale = 6'd16; s_exp = 10; v0 = n_dv;
    send_frame(8'h96, 1'b1, 1'b1, 16);
    send_frame(8'h0F, 1'b1, 1'b1, 16);
    step(5);
    qsz = dv_q.size();
    check_eq("t6_dv_count", 32'(n_dv - v0), 2);
    check_eq("t6_gap", 32'(dv_gap), 177);
    check_eq("t6_data0", 32'(dv_q[qsz-2]), 32'h96);
    check_eq("t6_data1", 32'(dv_q[qsz-1]), 32'h0F);
    check_eq("t6_deser_edge", 32'(deser_bad), 0);
    check_eq("t6_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Control FSM for the UART receiver. It sequences the shared edge/bit counter, data sampler, deserializer and the start/parity/stop checkers over one frame: start bit, DATA_WIDTH data bits, optional parity bit, stop bit. It qualifies the frame and emits a one-cycle data_valid pulse with sticky error status. It sits in the UART RX top beside the counter, which it drives through cnt_en and observes through bit_cnt and edge_cnt.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_BITS, 6, width of prescale and edge_cnt (prescale values 8/16/32)
TX_BITS, 4, width of bit_cnt; must satisfy 2^TX_BITS > DATA_WIDTH+2

Ports:
CLK  in  1  single clock; all state changes on its rising edge
RST  in  1  asynchronous, active-high reset
RX_IN  in  1  serial line, idle high; already synchronised upstream
PAR_EN  in  1  1 = frame carries a parity bit
prescale  in  PRESCALE_BITS  oversampling ratio P; stable while busy=1
bit_cnt  in  TX_BITS  from counter: 0 = start bit, 1..DATA_WIDTH = data, DATA_WIDTH+1 = parity or stop
edge_cnt  in  PRESCALE_BITS  from counter: 0..P-1 within current bit
strt_glitch  in  1  start checker result, valid from the edge after strt_chk_en
par_err  in  1  parity checker result, valid from the edge after par_chk_en
stp_err  in  1  stop checker result, valid from the edge after stp_chk_en
cnt_en  out  1  counter Enable; low clears the counter
dat_samp_en  out  1  sampler enable
deser_en  out  1  one-cycle shift strobe for the deserializer
strt_chk_en  out  1  one-cycle strobe
par_chk_en  out  1  one-cycle strobe
stp_chk_en  out  1  one-cycle strobe
data_valid  out  1  registered one-cycle frame-good pulse
parity_error  out  1  registered frame status
framing_error  out  1  registered frame status
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset applies asynchronously. State goes to IDLE; data_valid, parity_error, framing_error and par_flag are 0. Combinational strobes follow from IDLE, so all are 0 while RX_IN=1.
- The sample point is S = P/2+2, the edge after the sampler's 3-sample majority at P/2-1..P/2+1. The bit end is E = P-1. Compare in PRESCALE_BITS+1 bits so there is no underflow.
- cnt_en = (state in START/DATA/PARITY/STOP) OR (state==IDLE AND RX_IN==0 AND P>=8). The detect cycle is therefore edge 0 of the start bit.
- dat_samp_en = cnt_en.
- Strobes fire for exactly one cycle at edge_cnt==S:
  - strt_chk_en in START
  - deser_en in DATA
  - par_chk_en in PARITY
  - stp_chk_en in STOP
- Transitions:
  - IDLE -> START: RX_IN==0 and P>=8. If P<8, start detection is ignored.
  - START at E: strt_glitch=1 -> IDLE (silent drop, no status update); otherwise -> DATA.
  - DATA at E with bit_cnt==DATA_WIDTH: -> PARITY if PAR_EN, else -> STOP. PAR_EN is sampled at this decision only.
  - PARITY at E: par_flag <= par_err; -> STOP.
  - STOP at E: -> DONE.
- DONE lasts one cycle with cnt_en=0, so the counter clears.
  - parity_error <= par_flag; framing_error <= stp_err.
  - data_valid pulses only if both are 0.
  - par_flag clears; -> IDLE.
- Status outputs hold until the next DONE.
- Back-to-back frames: a start bit with RX_IN low during DONE is detected in the following IDLE cycle. The one-cycle slip is within the majority-sampling tolerance.
- Reset mid-frame: immediate return to IDLE. No data_valid and no status change afterwards, until a fresh start bit is seen.
- Frame length is (2 + DATA_WIDTH + PAR_EN)*P + 1 cycles, start detect to DONE inclusive.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum: IDLE, START, DATA, PARITY, STOP, DONE
  - MIN_PRESCALE = 8
  - sample-point offset 2
- No sub-module. The FSM is a state register plus combinational output decode.

Test Plan:
- P=8, PAR_EN=0, byte 0xA5, clean stop -> one data_valid at cycle 81 after start detect; both errors 0; deser_en pulses exactly 8 times, each at edge_cnt=6.
- P=16, PAR_EN=1, byte 0x3C with forced par_err=1 -> no data_valid; parity_error=1 in DONE and held; next clean frame clears it with data_valid=1.
- P=8, RX_IN low for 2 cycles only, strt_glitch=1 -> FSM returns to IDLE at edge 7; no strobes after strt_chk_en; status unchanged.
- P=32, stop bit driven 0, stp_err=1 -> framing_error=1, data_valid=0; busy drops in the cycle after DONE.
- RST asserted at bit_cnt=4 of a frame -> state IDLE, cnt_en=0 and all outputs 0 in the same cycle; next full frame received correctly.
- Two frames back-to-back (P=16, PAR_EN=1) -> two data_valid pulses 177 cycles apart, both frames' data correct.
